// File: rtl/cache_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_controller : direct-mapped write-back cache sequencer (CPU <-> array <-> DDR)
// Optional macro CACHE_STATS_EN adds saturating hit/miss/writeback counters. Rev 1.0
// ---------------------------------------------------------------------------
module cache_controller #(
  parameter ADDR_WIDTH   = 28,
  parameter DATA_WIDTH   = 32,
  parameter BLOCK_SIZE   = 256,
  parameter OFFSET_WIDTH = 3,
  parameter INDEX_WIDTH  = 11,
  parameter TAG_WIDTH    = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_ready,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   cache_addr,
  output logic [BLOCK_SIZE-1:0]   cache_data_write,
  output logic                    cache_dirty_write,
  output logic                    cache_write_en,
  input  logic [BLOCK_SIZE-1:0]   cache_data_read,
  input  logic                    cache_dirty_read,
  input  logic                    cache_hit,
  input  logic [TAG_WIDTH-1:0]    cache_replace_tag,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [BLOCK_SIZE-1:0]   mem_wdata,
  input  logic [BLOCK_SIZE-1:0]   mem_rdata,
  input  logic                    mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             writeback_count
`endif
);

  localparam int WORDS = BLOCK_SIZE / DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_we;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH-1:0]   hit_word;
  logic [BLOCK_SIZE-1:0]   merged_line;

  logic [OFFSET_WIDTH-1:0] offset;
  logic [INDEX_WIDTH-1:0]  index;
  logic [TAG_WIDTH-1:0]    tag;

  assign offset     = req_addr[OFFSET_WIDTH-1:0];
  assign index      = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag        = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign cache_addr = req_addr;

  // Word selected for a load and the line with the store word merged in.
  always_comb begin
    hit_word    = '0;
    merged_line = cache_data_read;
    for (int w = 0; w < WORDS; w++) begin
      if (offset == OFFSET_WIDTH'(w)) begin
        hit_word = cache_data_read[w*DATA_WIDTH +: DATA_WIDTH];
        merged_line[w*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next        = state;
    busy              = (state != IDLE);
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = {tag, index, {OFFSET_WIDTH{1'b0}}};
    mem_wdata         = cache_data_read;
    cache_write_en    = 1'b0;
    cache_data_write  = merged_line;
    cache_dirty_write = 1'b1;
    case (state)
      IDLE: begin
        if (cpu_req && !cpu_ready) state_next = COMPARE;
      end
      COMPARE: begin
        if (cache_hit) begin
          cache_write_en = req_we;
          state_next     = IDLE;
        end else begin
          state_next = cache_dirty_read ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {cache_replace_tag, index, {OFFSET_WIDTH{1'b0}}};
        if (mem_ack) state_next = FILL;
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          cache_write_en    = 1'b1;
          cache_data_write  = mem_rdata;
          cache_dirty_write = 1'b0;
          state_next        = COMPARE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch and CPU response; a request is not re-latched while cpu_ready is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      if (state == IDLE && cpu_req && !cpu_ready) begin
        req_addr  <= cpu_addr;
        req_we    <= cpu_we;
        req_wdata <= cpu_wdata;
      end
      if (state == COMPARE && cache_hit) begin
        cpu_ready <= 1'b1;
        if (!req_we) cpu_rdata <= hit_word;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic after_fill;

  // The retried compare after a fill is part of the miss, not a separate hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      after_fill      <= 1'b0;
      hit_count       <= '0;
      miss_count      <= '0;
      writeback_count <= '0;
    end else begin
      after_fill <= (state == FILL);
      if (state == COMPARE && cache_hit && !after_fill && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (state == COMPARE && !cache_hit && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
      if (state == WRITEBACK && mem_ack && writeback_count != 32'hFFFF_FFFF)
        writeback_count <= writeback_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// tb_cache_controller : randomized scoreboard bench with array and DDR models.
module tb_cache_controller;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int BS = 256;
  localparam int OW = 3;
  localparam int IW = 11;
  localparam int TW = 14;
  localparam int WORDS = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready, busy;
  logic [AW-1:0] cache_addr;
  logic [BS-1:0] cache_data_write, cache_data_read;
  logic          cache_dirty_write, cache_write_en, cache_dirty_read, cache_hit;
  logic [TW-1:0] cache_replace_tag;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [BS-1:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count, miss_count, writeback_count;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy),
    .cache_addr(cache_addr), .cache_data_write(cache_data_write),
    .cache_dirty_write(cache_dirty_write), .cache_write_en(cache_write_en),
    .cache_data_read(cache_data_read), .cache_dirty_read(cache_dirty_read),
    .cache_hit(cache_hit), .cache_replace_tag(cache_replace_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
  );

  // ---------------- cache array model ----------------
  logic [BS-1:0] arr_data  [2**IW];
  logic [TW-1:0] arr_tag   [2**IW];
  logic          arr_valid [2**IW];
  logic          arr_dirty [2**IW];
  logic          arr_init = 1'b1;
  logic [IW-1:0] a_idx;

  assign a_idx             = cache_addr[OW +: IW];
  assign cache_data_read   = arr_data[a_idx];
  assign cache_dirty_read  = arr_dirty[a_idx];
  assign cache_replace_tag = arr_tag[a_idx];
  assign cache_hit         = arr_valid[a_idx] && (arr_tag[a_idx] == cache_addr[AW-1 -: TW]);

  always @(posedge clk) begin
    if (arr_init) begin
      for (int i = 0; i < 2**IW; i++) begin
        arr_data[i]  <= '0;
        arr_tag[i]   <= '0;
        arr_valid[i] <= 1'b0;
        arr_dirty[i] <= 1'b0;
      end
    end else if (cache_write_en) begin
      arr_data[a_idx]  <= cache_data_write;
      arr_tag[a_idx]   <= cache_addr[AW-1 -: TW];
      arr_valid[a_idx] <= 1'b1;
      arr_dirty[a_idx] <= cache_dirty_write;
    end
  end

  // ---------------- backing memory contents ----------------
  function automatic logic [31:0] init_word(logic [AW-1:0] a);
    if (a == 28'h0000010) return 32'hAAAA5555;
    return ({4'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [AW-1:0] blk(logic [AW-1:0] a);
    return {a[AW-1:OW], {OW{1'b0}}};
  endfunction

  logic [BS-1:0] ddr [logic [AW-1:0]];

  function automatic logic [BS-1:0] ddr_rd(logic [AW-1:0] b);
    logic [BS-1:0] v;
    if (ddr.exists(b)) return ddr[b];
    for (int w = 0; w < WORDS; w++) v[w*DW +: DW] = init_word(b + AW'(w));
    return v;
  endfunction

  // DDR responder: acks after 0..3 extra cycles, possibly in the first cycle of mem_req.
  logic ack_en = 1'b1;
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst_n && mem_req && ack_en) begin
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) ddr[mem_addr] = mem_wdata;
          else        mem_rdata = ddr_rd(mem_addr);
          wcnt = $urandom_range(0, 3);
        end else begin
          wcnt = wcnt - 1;
        end
      end
    end
  end

  // ---------------- reference model (flat memory + resident-block table) ----------------
  logic [31:0]   ref_mem   [logic [AW-1:0]];
  logic [TW-1:0] res_tag   [logic [IW-1:0]];
  logic          res_dirty [logic [IW-1:0]];

  function automatic logic [31:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [BS-1:0] ref_block(logic [AW-1:0] b);
    logic [BS-1:0] v;
    for (int w = 0; w < WORDS; w++) v[w*DW +: DW] = ref_rd(b + AW'(w));
    return v;
  endfunction

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          miss;
    logic          dirty;
    logic [AW-1:0] victim;
    logic [BS-1:0] victim_data;
    logic [BS-1:0] line;
    logic [31:0]   issue;
  } exp_t;

  exp_t          exp_q [$];
  string         chk_name [$];
  logic [BS-1:0] chk_act [$];
  logic [BS-1:0] chk_exp [$];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(string name, logic [BS-1:0] act, logic [BS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic post(string name, logic [BS-1:0] act, logic [BS-1:0] exp);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  // ---------------- monitor ----------------
  int   wb_cnt = 0;
  int   fill_cnt = 0;
  logic legal;
  exp_t e;

  always @(negedge clk) begin
    while (chk_name.size() > 0) check(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
    if (!rst_n) begin
      wb_cnt   = 0;
      fill_cnt = 0;
    end else begin
      if (mem_req && mem_we) begin
        wb_cnt++;
        if (wb_cnt == 1 && exp_q.size() > 0) begin
          check("wb_addr", BS'(mem_addr), BS'(exp_q[0].victim));
          check("wb_data", mem_wdata, exp_q[0].victim_data);
        end
      end
      if (mem_req && !mem_we) begin
        fill_cnt++;
        if (fill_cnt == 1 && exp_q.size() > 0)
          check("fill_addr", BS'(mem_addr), BS'(blk(exp_q[0].addr)));
      end
      if (cache_write_en) begin
        legal = (mem_req && !mem_we && mem_ack) ||
                (!mem_req && busy && exp_q.size() > 0 && exp_q[0].we);
        check("write_en_legal", BS'(legal), BS'(1'b1));
        if (legal && !mem_req) begin
          check("store_line", cache_data_write, exp_q[0].line);
          check("store_dirty", BS'(cache_dirty_write), BS'(1'b1));
        end
      end
      if (cpu_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", BS'(1'b1), BS'(1'b0));
        end else begin
          e = exp_q.pop_front();
          if (!e.we) check("load_data", BS'(cpu_rdata), BS'(e.data));
          check("latency", BS'(cyc - e.issue), e.miss ? BS'(3 + wb_cnt + fill_cnt) : BS'(2));
          check("miss", BS'(fill_cnt > 0), BS'(e.miss));
          check("writeback", BS'(wb_cnt > 0), BS'(e.dirty));
        end
        wb_cnt   = 0;
        fill_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(logic we, logic [AW-1:0] addr, logic [31:0] wd);
    exp_t          x;
    logic [IW-1:0] idx;
    logic [TW-1:0] t;
    int            n;
    idx = addr[OW +: IW];
    t   = addr[AW-1 -: TW];
    x             = '0;
    x.we          = we;
    x.addr        = addr;
    x.issue       = cyc;
    x.miss        = !(res_tag.exists(idx) && res_tag[idx] == t);
    x.dirty       = x.miss && res_dirty.exists(idx) && res_dirty[idx];
    if (x.dirty) begin
      x.victim      = {res_tag[idx], idx, {OW{1'b0}}};
      x.victim_data = ref_block(x.victim);
    end
    res_tag[idx]   = t;
    res_dirty[idx] = (x.miss ? 1'b0 : res_dirty[idx]) | we;
    if (we) ref_mem[addr] = wd;
    x.data = ref_rd(addr);
    x.line = ref_block(blk(addr));
    exp_q.push_back(x);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 200);
    if (!cpu_ready) begin
      $display("FAIL timeout: no cpu_ready for addr %h after %0d cycles", addr, n);
      $fatal(1);
    end
    // Request stays asserted through the ready cycle; it must not be taken twice.
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] rt_addr;
    int            n;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge clk);
    arr_init = 1'b0;
    post("rst_cpu_ready", BS'(cpu_ready), '0);
    post("rst_cpu_rdata", BS'(cpu_rdata), '0);
    post("rst_busy", BS'(busy), '0);
    post("rst_mem_req", BS'(mem_req), '0);
    post("rst_write_en", BS'(cache_write_en), '0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 28'h0000010, 32'h0);
    issue(1'b0, 28'h0000013, 32'h0);
    issue(1'b1, 28'h0000012, 32'hDEADBEEF);
    issue(1'b0, 28'h0000012, 32'h0);
    issue(1'b0, 28'h0000013, 32'h0);
    issue(1'b0, 28'h0004010, 32'h0);

    // Abort a fill by reset while DDR withholds the ack.
    rt_addr  = {14'd7, 11'd5, 3'd1};
    ack_en   = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = rt_addr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && !mem_we) && n < 50);
    post("abort_reached_fill", BS'(mem_req && !mem_we), BS'(1'b1));
    @(negedge clk);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    post("abort_mem_req", BS'(mem_req), '0);
    post("abort_busy", BS'(busy), '0);
    post("abort_cpu_ready", BS'(cpu_ready), '0);
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    issue(1'b0, rt_addr, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      a = {TW'($urandom_range(0, 3)), IW'($urandom_range(0, 3)), OW'($urandom_range(0, 7))};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (5) @(negedge clk);
    post("queue_drained", BS'(exp_q.size()), '0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM between the CPU load/store port, the direct-mapped write-back cache array, and the DDR block interface.
- Latches one CPU word request and checks hit/miss against the array.
- On a miss, writes back a dirty victim block, fills the line from DDR, then completes the access.
- One outstanding request at a time. Write-allocate, write-back policy.

Parameters:
ADDR_WIDTH, 28, word address width (CPU and DDR)
DATA_WIDTH, 32, CPU word width
BLOCK_SIZE, 256, cache line width in bits
OFFSET_WIDTH, 3, log2(BLOCK_SIZE/DATA_WIDTH), word-in-block offset bits
INDEX_WIDTH, 11, cache line index bits
TAG_WIDTH, 14, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  request; held high until cpu_ready
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_WIDTH  word address
cpu_wdata  in  DATA_WIDTH  store data
cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
busy  out  1  high whenever state!=IDLE
cache_addr  out  ADDR_WIDTH  address to array (latched request address)
cache_data_write  out  BLOCK_SIZE  line to write
cache_dirty_write  out  1  dirty bit to write
cache_write_en  out  1  array write strobe
cache_data_read  in  BLOCK_SIZE  line at cache_addr (combinational)
cache_dirty_read  in  1  dirty bit at cache_addr
cache_hit  in  1  valid & tag match at cache_addr
cache_replace_tag  in  TAG_WIDTH  stored tag at cache_addr
mem_req  out  1  DDR request, held until mem_ack
mem_we  out  1  1=block write, 0=block read
mem_addr  out  ADDR_WIDTH  block-aligned address (offset bits 0)
mem_wdata  out  BLOCK_SIZE  writeback data
mem_rdata  in  BLOCK_SIZE  fill data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; cpu_ready=0, cpu_rdata=0, latched addr/we/wdata=0.
  - Combinational outputs in IDLE: mem_req=0, mem_we=0, cache_write_en=0, busy=0.
  - Reset mid-transaction aborts immediately. mem_req drops the cycle after reset is sampled. No array write occurs.
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE:
  - If cpu_req=1 and cpu_ready=0: latch cpu_addr/cpu_we/cpu_wdata, go to COMPARE.
  - Requests are never latched in any other state, or in the cycle cpu_ready=1.
- COMPARE, cache_hit=1, load:
  - cpu_rdata <= word[offset] of cache_data_read. Word w occupies bits [w*DATA_WIDTH +: DATA_WIDTH].
  - cpu_ready <= 1; go to IDLE.
- COMPARE, cache_hit=1, store:
  - cache_write_en=1 this cycle.
  - cache_data_write = cache_data_read with word[offset] replaced by latched wdata; cache_dirty_write=1.
  - cpu_ready <= 1; go to IDLE.
- COMPARE, cache_hit=0: go to WRITEBACK if cache_dirty_read=1, else FILL.
- Lines never written since reset read as clean. The bench preloads dirty bits to 0.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - mem_addr={cache_replace_tag, index, OFFSET_WIDTH'b0}; mem_wdata=cache_data_read.
  - On mem_ack go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={latched tag, index, 0}.
  - On mem_ack: cache_write_en=1, cache_data_write=mem_rdata, cache_dirty_write=0; go to COMPARE.
  - The retried access then hits; store merging happens there.
- mem_ack may arrive in the first cycle of mem_req. mem_ack outside WRITEBACK/FILL is ignored.
- cpu_ready is high for exactly one cycle; cpu_rdata holds its value until the next load completes.
- Latency, req sampled to cpu_ready:
  - hit: 2 cycles
  - clean miss: 3 + fill wait cycles
  - dirty miss: adds the writeback wait.
- busy = (state != IDLE).

Optional Feature:
CACHE_STATS_EN:
- When defined, adds 32-bit outputs hit_count, miss_count, writeback_count. All reset to 0 and saturate at 0xFFFFFFFF.
- hit_count increments on a COMPARE hit not immediately following FILL.
- miss_count increments on a COMPARE miss.
- writeback_count increments on mem_ack in WRITEBACK.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then load 0x0000010 (line clean, invalid) -> FILL with mem_addr=0x0000010; mem_rdata word0=0xAAAA5555 at ack -> cpu_rdata=0xAAAA5555, cpu_ready pulse, no WRITEBACK.
- Load 0x0000013 right after -> hit; cpu_ready 2 cycles after req with word3 of filled line; no mem_req.
- Store 0xDEADBEEF to 0x0000012 -> hit; cache_write_en one cycle, dirty=1, only word2 changed; next load of 0x0000012 returns 0xDEADBEEF.
- Load 0x0004010 (same index, new tag) -> WRITEBACK mem_we=1, mem_addr=0x0000010 with dirty line, then FILL 0x0004010, then cpu_ready.
- Assert rst_n=0 during FILL with mem_ack held off -> next cycle mem_req=0, busy=0, no cache_write_en; following request starts fresh.
- mem_ack in same cycle as first mem_req, plus cpu_req held across cpu_ready -> exactly one transaction per request, no duplicate latch.
